sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Time-multiplexed display scanner that shares one 7-segment decoder across DIGITS digit positions. It accepts a packed hex value through a valid/ready load port and double-buffers it so updates never tear a frame. It then sequences digit enables with programmable dwell and inter-digit blanking. It sits between the counter/datapath logic and the physical display, replacing per-digit decoders.

## Interface
- DIGITS, 4, number of digit positions scanned (legal 1..8)
- DWELL, 8, cycles each digit is driven per frame (legal ≥1)
- BLANK, 1, all-off cycles after each digit (legal ≥0; 0 = no gap state)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- load_valid  in  1  new display value offered
- load_data  in  4*DIGITS  packed nibbles; nibble i = digit i, nibble 0 least significant
- load_ready  out  1  pending buffer empty; value accepted when load_valid && load_ready at clock edge
- lz_blank  in  1  leading-zero blanking enable (sampled every cycle)
- seg  out  7  segments, bit6=a … bit0=g, active-high
- an  out  DIGITS  one-hot digit enable, an[i] = digit i, active-high
- frame_done  out  1  one-cycle pulse in last cycle of each frame

## Operation
- Registers: disp (4*DIGITS, shown value), pend (4*DIGITS) plus pend_full, digit index, dwell/blank counter, state.
- States: SHOW (an one-hot at current index, seg = decode(nibble)) for DWELL cycles, then GAP (an=0, seg=0) for BLANK cycles, then next index; after index DIGITS-1, wrap to 0. BLANK=0: SHOW→SHOW of next digit directly.
- Decode table 0..F: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 (hex, bits a..g).
- Leading-zero blanking: if lz_blank=1 and nibble i and all higher nibbles of disp are 0, digit i in SHOW drives an=0, seg=0; digit 0 never blanked (value 0 shows 7E). Timing slots are unchanged.
- Load: accept → pend<=load_data, pend_full<=1. load_ready = !pend_full.
- Frame boundary (edge ending the last cycle of the frame): if pend_full, disp<=pend, pend_full<=0. Data accepted on that same edge (pend was empty) waits for the next boundary.
- Reset values: seg=0, an=0, frame_done=0, load_ready=0 while reset is high; disp=0, pend_full=0, index=0, state=SHOW, counter=0. Reset mid-frame aborts the scan and discards pending data.

## Timing
- Cycle k = state after the k-th rising edge with reset low (k=1 first).
- seg/an/frame_done are registered and aligned with state. Digit i is driven in cycles i·P+1 … i·P+DWELL, where P=DWELL+BLANK. Frame length F=DIGITS·P.
- frame_done=1 in cycles n·F, n≥1; otherwise 0.
- load_ready=1 from cycle 1. It falls the cycle after acceptance and rises the cycle after the transferring boundary.
- Latency: value accepted in frame n is displayed from the first cycle of frame n+1. If accepted on frame n's closing edge, it is displayed from frame n+2.
- At most one pending value; a held load_valid with load_ready=0 is not consumed.

## Test plan
- DIGITS=4, DWELL=4, BLANK=1, no load: an=0001 cycles 1-4, 0000 cycle 5, 0010 cycles 6-9 … 1000 cycles 16-19; seg=7E whenever an≠0; frame_done only at cycles 20 and 40.
- load 16'h12AF at cycle 3: load_ready=0 cycles 4-20. Frame 2 shows digit0..3 seg=47,77,6D,30; load_ready=1 at cycle 21.
- lz_blank=1 with 16'h0005: only an=0001 with seg=5B; other slots an=0, seg=0. With 16'h0000: digit0 seg=7E. With 16'h0500: digits 0-2 shown (7E,7E,5B), digit3 blanked.
- Back-to-back loads 16'h1111 (cycle 2) and 16'h2222 (load_valid held from cycle 3): second accepted on the edge completing cycle 21; frame 2 shows 30 and frame 3 shows 6D on all digits.
- Reset asserted cycle 12 with value pending: next cycle seg=0, an=0, load_ready=0. After release, frame shows 7E on all digits and pending data never appears.
- BLANK=0, DWELL=2: an 0001,0001,0010,0010,… with no all-zero cycle; frame_done at cycle 8.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: one shared decoder, double-buffered load
// port, programmable dwell and blanking per digit, optional leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 8,
    parameter int unsigned BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int unsigned CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_C  = CW'(DWELL);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic {SHOW, GAP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;
    logic [3:0]            nib;
    logic                  lz_hit;
    logic                  accept;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    assign accept     = load_valid && ready_q;
    assign load_ready = ready_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

    // Counter holds the 1-based cycle number within the current state; the
    // reset value 0 acts as a pre-cycle so the first live cycle is SHOW/count 1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            SHOW: begin
                if (cnt_q == DWELL_C) begin
                    cnt_d = CW'(1);
                    if (BLANK > 0) begin
                        state_d = GAP;
                    end else begin
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    end
                end
            end
            GAP: begin
                if (cnt_q == BLANK_C) begin
                    state_d = SHOW;
                    cnt_d   = CW'(1);
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // fd_q marks the last cycle of a frame, so its closing edge is the boundary.
    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (fd_q && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        seg_d  = '0;
        an_d   = '0;
        nib    = '0;
        lz_hit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib    = disp_d[4*i +: 4];
                lz_hit = lz_blank && (i != 0) && ((disp_d >> (4*i)) == '0);
            end
        end
        if (state_d == SHOW && !lz_hit) begin
            an_d  = DIGITS'(1) << idx_d;
            seg_d = decode(nib);
        end
        if (BLANK > 0) begin
            fd_d = (idx_d == LAST_IDX) && (state_d == GAP) && (cnt_d == BLANK_C);
        end else begin
            fd_d = (idx_d == LAST_IDX) && (state_d == SHOW) && (cnt_d == DWELL_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SHOW;
            idx_q       <= '0;
            cnt_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b0;
            seg_q       <= '0;
            an_q        <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a cycle-position model predicts every
// output cycle; scenario tasks add spot checks of the documented timing points.
module tb_sevenseg_scan_ctrl;
    localparam int F  = 20;
    localparam int P  = 5;
    localparam int DW = 4;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
        logic       rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    logic        nb_valid = 1'b0;
    logic [15:0] nb_data  = 16'h0000;
    logic        nb_lz    = 1'b0;
    logic        nb_ready;
    logic [6:0]  nb_seg;
    logic [3:0]  nb_an;
    logic        nb_fd;

    exp_t        sb[$];
    int          asserts = 0;
    int          fails   = 0;
    int          k       = 0;
    logic [6:0]  segtab [16];
    logic [15:0] m_disp, m_pend;
    bit          m_full, m_ready;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(1)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .lz_blank(lz_blank), .seg(seg), .an(an),
        .frame_done(frame_done)
    );

    sevenseg_scan_ctrl #(.DIGITS(4), .DWELL(2), .BLANK(0)) dut_nb (
        .clk(clk), .reset(reset), .load_valid(nb_valid), .load_data(nb_data),
        .load_ready(nb_ready), .lz_blank(nb_lz), .seg(nb_seg), .an(nb_an),
        .frame_done(nb_fd)
    );

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == k) begin
            e = sb.pop_front();
            asserts++;
            if (seg !== e.seg) begin
                fails++;
                $display("FAIL sb_seg cycle %0d: got %h expected %h", k, seg, e.seg);
            end
            asserts++;
            if (an !== e.an) begin
                fails++;
                $display("FAIL sb_an cycle %0d: got %b expected %b", k, an, e.an);
            end
            asserts++;
            if (frame_done !== e.fd) begin
                fails++;
                $display("FAIL sb_frame_done cycle %0d: got %b expected %b", k, frame_done, e.fd);
            end
            asserts++;
            if (load_ready !== e.rdy) begin
                fails++;
                $display("FAIL sb_load_ready cycle %0d: got %b expected %b", k, load_ready, e.rdy);
            end
        end
    end

    // Called at the end of cycle k with the inputs of cycle k; predicts cycle k+1.
    task automatic model_advance(input logic v, input logic [15:0] d, input logic lz);
        exp_t        e;
        int          n, pos, dig;
        logic [15:0] upper;
        logic [3:0]  nib;
        bit          acc;
        acc = v && m_ready;
        if (k > 0 && (k % F) == 0 && m_full) begin
            m_disp = m_pend;
            m_full = 0;
        end
        if (acc) begin
            m_pend = d;
            m_full = 1;
        end
        n     = k + 1;
        pos   = (n - 1) % F;
        dig   = pos / P;
        upper = m_disp >> (4 * dig);
        nib   = upper[3:0];
        e.cyc = n;
        e.rdy = !m_full;
        e.fd  = ((n % F) == 0);
        m_ready = e.rdy;
        if ((pos % P) < DW && !(lz && dig != 0 && upper == 16'h0000)) begin
            e.an  = 4'(1 << dig);
            e.seg = segtab[nib];
        end else begin
            e.an  = 4'b0000;
            e.seg = 7'h00;
        end
        sb.push_back(e);
    endtask

    task automatic tick(input logic v, input logic [15:0] d, input logic lz);
        @(posedge clk);
        #1;
        k++;
        load_valid = v;
        load_data  = d;
        lz_blank   = lz;
        model_advance(v, d, lz);
    endtask

    task automatic release_reset(input logic lz);
        reset   = 1'b0;
        k       = 0;
        m_disp  = 16'h0000;
        m_pend  = 16'h0000;
        m_full  = 0;
        m_ready = 0;
        model_advance(1'b0, 16'h0000, lz);
    endtask

    task automatic do_reset(input logic lz);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        load_valid = 1'b0;
        lz_blank   = lz;
        sb.delete();
        k = 0;
        repeat (2) @(posedge clk);
        #1;
        asserts++;
        if (seg !== 7'h00) begin fails++; $display("FAIL reset_seg: got %h expected 00", seg); end
        asserts++;
        if (an !== 4'b0000) begin fails++; $display("FAIL reset_an: got %b expected 0000", an); end
        asserts++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        asserts++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
        asserts++;
        if (nb_an !== 4'b0000) begin fails++; $display("FAIL reset_nb_an: got %b expected 0000", nb_an); end
        release_reset(lz);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
    endtask

    task automatic test_scan();
        logic [3:0] ean;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 16'h0000, 1'b0);
            ean = 4'(1 << (((k - 1) % 8) / 2));
            asserts++;
            if (nb_an !== ean) begin fails++; $display("FAIL blank0_an cycle %0d: got %b expected %b", k, nb_an, ean); end
            asserts++;
            if (nb_seg !== 7'h7E) begin fails++; $display("FAIL blank0_seg cycle %0d: got %h expected 7e", k, nb_seg); end
            asserts++;
            if (nb_fd !== ((k % 8) == 0)) begin fails++; $display("FAIL blank0_frame_done cycle %0d: got %b expected %b", k, nb_fd, (k % 8) == 0); end
            if (k == 5) begin
                asserts++;
                if (an !== 4'b0000) begin fails++; $display("FAIL scan_gap cycle 5: got %b expected 0000", an); end
            end
            if (k == 16) begin
                asserts++;
                if (an !== 4'b1000) begin fails++; $display("FAIL scan_digit3 cycle 16: got %b expected 1000", an); end
            end
        end
    endtask

    task automatic test_load();
        logic [6:0] es;
        bit         chk;
        for (int i = 1; i <= 40; i++) begin
            tick(i == 3, 16'h12AF, 1'b0);
            if (k == 4 || k == 20) begin
                asserts++;
                if (load_ready !== 1'b0) begin fails++; $display("FAIL load_busy cycle %0d: got %b expected 0", k, load_ready); end
            end
            if (k == 21) begin
                asserts++;
                if (load_ready !== 1'b1) begin fails++; $display("FAIL load_rearm cycle 21: got %b expected 1", load_ready); end
            end
            chk = 1;
            case (k)
                21: es = 7'h47;
                26: es = 7'h77;
                31: es = 7'h6D;
                36: es = 7'h30;
                default: chk = 0;
            endcase
            if (chk) begin
                asserts++;
                if (seg !== es) begin fails++; $display("FAIL load_frame2 cycle %0d: got %h expected %h", k, seg, es); end
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] d;
        logic [6:0]  es;
        logic [3:0]  ea;
        bit          chk;
        do_reset(1'b1);
        for (int i = 1; i <= 100; i++) begin
            d = (i == 1) ? 16'h0005 : (i == 41) ? 16'h0000 : 16'h0500;
            tick(i == 1 || i == 41 || i == 61, d, 1'b1);
            chk = 1;
            case (k)
                21: begin ea = 4'b0001; es = 7'h5B; end
                26: begin ea = 4'b0000; es = 7'h00; end
                61: begin ea = 4'b0001; es = 7'h7E; end
                66: begin ea = 4'b0000; es = 7'h00; end
                86: begin ea = 4'b0010; es = 7'h7E; end
                91: begin ea = 4'b0100; es = 7'h5B; end
                96: begin ea = 4'b0000; es = 7'h00; end
                default: chk = 0;
            endcase
            if (chk) begin
                asserts++;
                if (an !== ea || seg !== es) begin
                    fails++;
                    $display("FAIL lz_slot cycle %0d: got an=%b seg=%h expected an=%b seg=%h", k, an, seg, ea, es);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] es;
        bit         chk;
        do_reset(1'b0);
        for (int i = 1; i <= 60; i++) begin
            tick(i >= 2 && i <= 21, (i == 2) ? 16'h1111 : 16'h2222, 1'b0);
            if (k == 21 || k == 22) begin
                asserts++;
                if (load_ready !== (k == 21)) begin fails++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", k, load_ready, k == 21); end
            end
            chk = 1;
            case (k)
                21: es = 7'h30;
                36: es = 7'h30;
                41: es = 7'h6D;
                56: es = 7'h6D;
                default: chk = 0;
            endcase
            if (chk) begin
                asserts++;
                if (seg !== es) begin fails++; $display("FAIL b2b_seg cycle %0d: got %h expected %h", k, seg, es); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 1; i <= 12; i++) tick(i == 2, 16'h3333, 1'b0);
        asserts++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL mid_pending cycle 12: got %b expected 0", load_ready); end
        reset      = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        #1;
        sb.delete();
        @(posedge clk);
        #1;
        asserts++;
        if (seg !== 7'h00 || an !== 4'b0000 || load_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got seg=%h an=%b ready=%b expected 00 0000 0", seg, an, load_ready);
        end
        release_reset(1'b0);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 16'h0000, 1'b0);
            if (k == 16 || k == 36) begin
                asserts++;
                if (an !== 4'b1000 || seg !== 7'h7E) begin
                    fails++;
                    $display("FAIL mid_after cycle %0d: got an=%b seg=%h expected 1000 7e", k, an, seg);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        lz_blank   = 1'b0;
        segtab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        test_reset();
        test_scan();
        do_reset(1'b0);
        test_load();
        test_lz_blank();
        test_back_to_back();
        test_reset_mid();
        @(posedge clk);
        #1;
        asserts++;
        if (sb.size() > 1) begin fails++; $display("FAIL sb_drain: got %0d entries expected <=1", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
